pc_ir_fetch: RTL and testbench
==============================

// Module: pc_ir_fetch
// PURPOSE
//  Front end of the multi-cycle CPU: owns PC and the instruction register (IR), and fetches from instruction memory
//  with a req/ack handshake that tolerates wait states. Feeds opCode and decoded fields to the control unit and the
//  datapath; consumes PCWre/IRWre/PCSrc/ExtSel from the control unit. Raises fetch_stall so the CU holds in sIF.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  TIMEOUT    16             max cycles imem_req may stay unacknowledged before fetch_err (>=2)
//  HALT_WORD  32'hFC00_0000  word loaded into IR on timeout (opCode 6'b111111 = Halt)
// PORTS
//  CLK          in   1   clock, rising edge
//  RST          in   1   asynchronous, active-low reset
//  PCWre        in   1   PC write enable from CU
//  IRWre        in   1   fetch request from CU (high in sIF)
//  PCSrc        in   2   next-PC select: 00 PC+4, 01 branch, 10 jr, 11 jump
//  ExtSel       in   1   1 = sign-extend imm16, 0 = zero-extend
//  rs_data      in   32  register-file rs value (jr target)
//  imem_rdata   in   32  instruction word, valid when imem_ack=1
//  imem_ack     in   1   memory acknowledge; may be high in the same cycle as imem_req
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address (= pc)
//  pc           out  32  current instruction address
//  pc_plus4     out  32  pc + 4 (Jal link value)
//  ir           out  32  instruction register
//  opCode       out  6   ir[31:26]
//  rs/rt/rd     out  5   ir[25:21] / ir[20:16] / ir[15:11]
//  sa           out  5   ir[10:6]
//  ext_imm      out  32  ir[15:0] extended per ExtSel
//  fetch_stall  out  1   imem_req && !imem_ack
//  fetch_err    out  1   sticky: fetch timed out
//  misalign_err out  1   sticky: jr target had bits[1:0] != 0
// BEHAVIOUR
//  Reset (RST=0, async): pc=RESET_PC, ir=0, FSM=IDLE, wait counter=0, fetch_err=0, misalign_err=0; imem_req=0.
//  FSM IDLE / FETCH. imem_req = (IDLE && IRWre && !fetch_err) || FETCH (combinational, same-cycle issue).
//   IDLE: imem_req && imem_ack -> ir<=imem_rdata, stay IDLE; imem_req && !imem_ack -> FETCH, counter<=1.
//   FETCH: imem_ack -> ir<=imem_rdata, IDLE, counter<=0; else counter++.
//   FETCH with counter==TIMEOUT-1 and no ack -> ir<=HALT_WORD, fetch_err<=1, IDLE (req drops next cycle).
//   A late ack arriving after timeout is ignored. IRWre is not required to stay high once in FETCH.
//   fetch_err=1 blocks further fetches until reset.
//  Latency: zero-wait memory -> ir valid the cycle after IRWre; N wait states -> N extra cycles, fetch_stall high
//   for exactly those N cycles. ir holds its value except on ack or timeout.
//  One fetch per ack: if IRWre is still high in IDLE the cycle after an ack, a new fetch is issued (CU must drop it).
//  PC update at rising edge when PCWre && !fetch_stall:
//   00: pc+4;  01: pc+4 + (sext(ir[15:0])<<2);  10: {rs_data[31:2],2'b00};  11: {pc_plus4[31:28], ir[25:0], 2'b00}.
//   PCSrc=10 with rs_data[1:0]!=0 -> misalign_err<=1, still loads the word-aligned target.
//  All PC arithmetic is modulo 2^32 (wrap at 32'hFFFF_FFFC -> 0). Branch target uses current pc.
//  PCWre and imem_req in the same cycle: fetch uses pre-update pc; PC update is withheld while fetch_stall=1.
//  Reset mid-fetch: imem_req drops immediately (async); an ack in that cycle is ignored.
//  ext_imm, decoded fields, and pc_plus4 are combinational from ir/pc.
// TESTING
//  1 Reset release, IRWre=1 for 1 cycle, ack same cycle, rdata=32'h0822_0005 -> ir=32'h0822_0005, opCode=6'b000010,
//    rs=1, rt=2, pc=0, fetch_stall never high.
//  2 ack delayed 3 cycles -> fetch_stall high 3 cycles, imem_addr constant, ir updates on 4th edge only.
//  3 PCSrc=01, pc=32'h20, imm=16'hFFFE, PCWre pulse -> pc=32'h1C; PCSrc=00 at pc=32'hFFFF_FFFC -> pc=0.
//  4 PCSrc=11, pc=32'h1000_0040, ir[25:0]=26'h10 -> pc=32'h1000_0040; PCSrc=10, rs_data=32'h103 -> pc=32'h100,
//    misalign_err=1.
//  5 No ack for TIMEOUT cycles -> ir=32'hFC00_0000, fetch_err=1, imem_req low after; later IRWre issues no request.
//  6 RST low mid-FETCH with ack asserted -> imem_req=0 immediately, ir=0, pc=RESET_PC, errors cleared.

Source files
------------

// File: rtl/pc_ir_fetch.sv
// Fetch front end of the multi-cycle CPU: owns PC and IR, fetches over a req/ack
// handshake with wait-state tolerance and a timeout that forces a Halt into IR.
module pc_ir_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic [1:0]  PCSrc,
    input  logic        ExtSel,
    input  logic [31:0] rs_data,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic [5:0]  opCode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [31:0] ext_imm,
    output logic        fetch_stall,
    output logic        fetch_err,
    output logic        misalign_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JR     = 2'b10;
    localparam logic [1:0] SRC_JUMP   = 2'b11;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_ir;
    logic [31:0]      w_ir_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic             r_merr;
    logic             w_merr_nxt;

    logic             w_req;
    logic             w_stall;
    logic             w_pc_upd;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_off;
    logic             w_timeout;

    // Request is issued in the same cycle IRWre arrives; reset masks it asynchronously.
    assign w_req     = RST && (((r_state == S_IDLE) && IRWre && !r_ferr) || (r_state == S_FETCH));
    assign w_stall   = w_req && !imem_ack;
    assign w_pc_upd  = PCWre && !w_stall;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

    // Fetch FSM next-state and IR/error capture.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ir_nxt    = r_ir;
        w_ferr_nxt  = r_ferr;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (imem_ack) begin
                        w_ir_nxt = imem_rdata;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_ir_nxt    = imem_rdata;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_timeout) begin
                    w_ir_nxt    = HALT_WORD;
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Next-PC selection; a misaligned jr still loads the word-aligned target.
    always_comb begin
        w_pc_nxt   = r_pc;
        w_merr_nxt = r_merr;
        if (w_pc_upd) begin
            case (PCSrc)
                SRC_SEQ:    w_pc_nxt = w_pc_plus4;
                SRC_BRANCH: w_pc_nxt = w_pc_plus4 + w_br_off;
                SRC_JR: begin
                    w_pc_nxt = {rs_data[31:2], 2'b00};
                    if (rs_data[1:0] != 2'b00) begin
                        w_merr_nxt = 1'b1;
                    end
                end
                SRC_JUMP:   w_pc_nxt = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
                default:    w_pc_nxt = w_pc_plus4;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ir    <= '0;
            r_ferr  <= 1'b0;
            r_pc    <= RESET_PC;
            r_merr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ir    <= w_ir_nxt;
            r_ferr  <= w_ferr_nxt;
            r_pc    <= w_pc_nxt;
            r_merr  <= w_merr_nxt;
        end
    end

    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign fetch_stall  = w_stall;
    assign fetch_err    = r_ferr;
    assign misalign_err = r_merr;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign ir           = r_ir;
    assign opCode       = r_ir[31:26];
    assign rs           = r_ir[25:21];
    assign rt           = r_ir[20:16];
    assign rd           = r_ir[15:11];
    assign sa           = r_ir[10:6];
    assign ext_imm      = ExtSel ? {{16{r_ir[15]}}, r_ir[15:0]} : {16'h0000, r_ir[15:0]};

endmodule

// File: tb/tb_pc_ir_fetch.sv
// Self-checking bench for pc_ir_fetch: directed scenarios plus randomized fetch/PC
// sequences checked against an arithmetic reference model.
module tb_pc_ir_fetch;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PCWre, IRWre, ExtSel, imem_ack;
    logic [1:0]  PCSrc;
    logic [31:0] rs_data, imem_rdata;
    logic        imem_req, fetch_stall, fetch_err, misalign_err;
    logic [31:0] imem_addr, pc, pc_plus4, ir, ext_imm;
    logic [5:0]  opCode;
    logic [4:0]  rs, rt, rd, sa;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_pc, m_ir;
    logic        m_merr;

    pc_ir_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TO),
        .HALT_WORD(32'hFC00_0000)
    ) dut (
        .CLK(CLK), .RST(RST), .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc),
        .ExtSel(ExtSel), .rs_data(rs_data), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4), .ir(ir),
        .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .ext_imm(ext_imm),
        .fetch_stall(fetch_stall), .fetch_err(fetch_err), .misalign_err(misalign_err)
    );

    always #5 CLK = ~CLK;

    // Reference next-PC from the architectural rules, as plain arithmetic.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] p, input logic [31:0] i,
                                                input logic [1:0] s, input logic [31:0] r);
        int off;
        off = int'(i % 32'h0001_0000);
        if (off >= 32768) off = off - 65536;
        case (s)
            2'd0:    return p + 32'd4;
            2'd1:    return p + 32'd4 + 32'(off * 4);
            2'd2:    return r - (r % 32'd4);
            default: return ((p + 32'd4) & 32'hF000_0000) | ((i % 32'h0400_0000) * 32'd4);
        endcase
    endfunction

    task automatic apply_reset();
        RST = 1'b0; PCWre = 1'b0; IRWre = 1'b0; ExtSel = 1'b0; imem_ack = 1'b0;
        PCSrc = 2'b00; rs_data = '0; imem_rdata = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        m_pc = 32'h0; m_ir = 32'h0; m_merr = 1'b0;
    endtask

    // One fetch: ack after 'waits' stall cycles; reports stalls seen, early IR change, address drift.
    task automatic do_fetch(input logic [31:0] word, input int waits,
                            output int stalls, output logic early, output logic drift);
        logic [31:0] a0;
        a0 = '0; stalls = 0; early = 1'b0; drift = 1'b0;
        imem_rdata = word;
        IRWre = 1'b1;
        for (int c = 0; c <= waits; c++) begin
            imem_ack = (c == waits);
            #2;
            if (c == 0) a0 = imem_addr;
            else if (imem_addr !== a0) drift = 1'b1;
            if (fetch_stall) stalls++;
            if (ir !== m_ir) early = 1'b1;
            @(posedge CLK);
            #1 IRWre = 1'b0;
        end
        imem_ack = 1'b0;
        m_ir = word;
    endtask

    task automatic pc_step(input logic [1:0] src, input logic [31:0] r);
        PCSrc = src; rs_data = r; PCWre = 1'b1;
        if (src == 2'd2 && (r % 32'd4) != 0) m_merr = 1'b1;
        m_pc = ref_next_pc(m_pc, m_ir, src, r);
        @(posedge CLK);
        #1 PCWre = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        vectors++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=%h", ir, 32'h0); end
        vectors++; if ({imem_req, fetch_err, misalign_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {imem_req, fetch_err, misalign_err}); end
    endtask

    task automatic test_zero_wait();
        int st; logic early, drift;
        do_fetch(32'h0822_0005, 0, st, early, drift);
        #1;
        vectors++; if (st !== 0) begin errors++; $display("FAIL zw_stall got=%0d exp=0", st); end
        vectors++; if (ir !== 32'h0822_0005) begin errors++; $display("FAIL zw_ir got=%h exp=08220005", ir); end
        vectors++; if ({opCode, rs, rt} !== {6'd2, 5'd1, 5'd2}) begin
            errors++; $display("FAIL zw_fields got=%0d/%0d/%0d exp=2/1/2", opCode, rs, rt); end
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL zw_pc got=%h exp=0", pc); end
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_after got=%b exp=0", imem_req); end
    endtask

    // Three wait states with PCWre held: PC must advance exactly once, on the ack edge.
    task automatic test_wait_states();
        int st; logic early, drift; logic [31:0] p0;
        p0 = m_pc;
        PCSrc = 2'b00; PCWre = 1'b1;
        do_fetch(32'h1234_5678, 3, st, early, drift);
        PCWre = 1'b0;
        m_pc = p0 + 32'd4;
        #1;
        vectors++; if (st !== 3) begin errors++; $display("FAIL ws_stall got=%0d exp=3", st); end
        vectors++; if (early !== 1'b0) begin errors++; $display("FAIL ws_ir_early got=%b exp=0", early); end
        vectors++; if (drift !== 1'b0) begin errors++; $display("FAIL ws_addr_drift got=%b exp=0", drift); end
        vectors++; if (ir !== 32'h1234_5678) begin errors++; $display("FAIL ws_ir got=%h exp=12345678", ir); end
        vectors++; if (pc !== m_pc) begin errors++; $display("FAIL ws_pc got=%h exp=%h", pc, m_pc); end
    endtask

    task automatic test_branch_wrap();
        int st; logic early, drift;
        pc_step(2'b10, 32'h0000_0020);
        do_fetch(32'h1000_FFFE, 0, st, early, drift);
        pc_step(2'b01, 32'h0);
        #1;
        vectors++; if (pc !== 32'h0000_001C) begin errors++; $display("FAIL br_pc got=%h exp=0000001c", pc); end
        pc_step(2'b10, 32'hFFFF_FFFC);
        pc_step(2'b00, 32'h0);
        #1;
        vectors++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    endtask

    task automatic test_jump_jr();
        int st; logic early, drift;
        pc_step(2'b10, 32'h1000_0040);
        do_fetch(32'h0800_0010, 0, st, early, drift);
        pc_step(2'b11, 32'h0);
        #1;
        vectors++; if (pc !== 32'h1000_0040) begin errors++; $display("FAIL jump_pc got=%h exp=10000040", pc); end
        vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL jr_merr_pre got=%b exp=0", misalign_err); end
        pc_step(2'b10, 32'h0000_0103);
        #1;
        vectors++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL jr_pc got=%h exp=00000100", pc); end
        vectors++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL jr_merr got=%b exp=1", misalign_err); end
    endtask

    task automatic test_random();
        int st, waits; logic early, drift; logic [31:0] w, r, e_imm; logic [1:0] s; int v;
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            w = $urandom;
            waits = $urandom_range(0, 5);
            do_fetch(w, waits, st, early, drift);
            ExtSel = 1'($urandom_range(0, 1));
            v = int'(w % 32'h0001_0000);
            if (ExtSel && v >= 32768) v = v - 65536;
            e_imm = 32'(v);
            #1;
            vectors++; if (st !== waits) begin errors++; $display("FAIL rnd_stall k=%0d got=%0d exp=%0d", k, st, waits); end
            vectors++; if (early || drift) begin errors++; $display("FAIL rnd_hold k=%0d got=%b%b exp=00", k, early, drift); end
            vectors++; if (ir !== w) begin errors++; $display("FAIL rnd_ir k=%0d got=%h exp=%h", k, ir, w); end
            vectors++; if ({rd, sa} !== 10'((w / 32'd64) % 32'd1024)) begin
                errors++; $display("FAIL rnd_rdsa k=%0d got=%0d/%0d exp_word=%h", k, rd, sa, w); end
            vectors++; if (ext_imm !== e_imm) begin
                errors++; $display("FAIL rnd_ext k=%0d got=%h exp=%h", k, ext_imm, e_imm); end
            s = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            pc_step(s, r);
            #1;
            vectors++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc k=%0d src=%0d got=%h exp=%h", k, s, pc, m_pc); end
            vectors++; if (pc_plus4 !== m_pc + 32'd4) begin
                errors++; $display("FAIL rnd_pc4 k=%0d got=%h exp=%h", k, pc_plus4, m_pc + 32'd4); end
            vectors++; if (misalign_err !== m_merr) begin
                errors++; $display("FAIL rnd_merr k=%0d got=%b exp=%b", k, misalign_err, m_merr); end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        cnt = 0;
        imem_ack = 1'b0;
        IRWre = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (!imem_req) break;
            cnt++;
            @(posedge CLK);
            #1;
        end
        vectors++; if (cnt !== TO) begin errors++; $display("FAIL to_req_cycles got=%0d exp=%0d", cnt, TO); end
        vectors++; if (ir !== 32'hFC00_0000) begin errors++; $display("FAIL to_ir got=%h exp=fc000000", ir); end
        vectors++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", fetch_err); end
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL to_blocked_req got=%b exp=0", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        @(posedge CLK);
        #1 imem_ack = 1'b0;
        #1;
        vectors++; if (ir !== 32'hFC00_0000) begin errors++; $display("FAIL to_late_ack got=%h exp=fc000000", ir); end
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL to_still_blocked got=%b exp=0", imem_req); end
        IRWre = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        pc_step(2'b10, 32'h0000_0207);
        #1;
        vectors++; if (misalign_err !== 1'b1 || pc !== 32'h204) begin
            errors++; $display("FAIL rm_setup got=%b/%h exp=1/00000204", misalign_err, pc); end
        IRWre = 1'b1; imem_ack = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1 RST = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got=%b exp=0", imem_req); end
        @(posedge CLK);
        #1;
        vectors++; if (ir !== 32'h0 || pc !== 32'h0) begin
            errors++; $display("FAIL rm_state got=%h/%h exp=0/0", ir, pc); end
        vectors++; if ({fetch_err, misalign_err, fetch_stall} !== 3'b000) begin
            errors++; $display("FAIL rm_flags got=%b exp=000", {fetch_err, misalign_err, fetch_stall}); end
        IRWre = 1'b0; imem_ack = 1'b0;
        RST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch_wrap();
        test_jump_jr();
        test_random();
        test_timeout();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
